// File: rtl/regfile_2w3r.sv
// Two-write, three-read register file with write-first forwarding, read stall hold,
// synchronous clear and write-conflict flag. The top index is not stored and reads return PC_IN.
module regfile_2w3r #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 2**ADDR_W - 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] RA3,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [DATA_W-1:0] WD2,
    input  logic [DATA_W-1:0] PC_IN,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] RD3,
    output logic              WCONFLICT
);

    localparam int                NREGS     = 2**ADDR_W - 1;
    localparam int                NPORTS    = 3;
    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] rd_q   [NPORTS];
    logic [DATA_W-1:0] rd_d   [NPORTS];
    logic [ADDR_W-1:0] ra     [NPORTS];
    logic              wconflict_q;
    logic              wconflict_d;
    logic              wr1_ok;
    logic              wr2_ok;

    assign ra[0] = RA1;
    assign ra[1] = RA2;
    assign ra[2] = RA3;

    assign wr1_ok = WE1 && (WA1 != PC_ADDR);
    assign wr2_ok = WE2 && (WA2 != PC_ADDR);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr1_ok && (WA1 == ADDR_W'(i))) regs_d[i] = WD1;
            // Port 2 is applied last so load data overrides the ALU result.
            if (wr2_ok && (WA2 == ADDR_W'(i))) regs_d[i] = WD2;
        end
    end

    // Read mux, lowest priority first so later assignments win: storage, WD1, WD2, PC.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            rd_d[p] = '0;
            for (int i = 0; i < NREGS; i++) begin
                if (ra[p] == ADDR_W'(i)) rd_d[p] = regs_q[i];
            end
            if (WE1 && (WA1 == ra[p])) rd_d[p] = WD1;
            if (WE2 && (WA2 == ra[p])) rd_d[p] = WD2;
            if (ra[p] == PC_ADDR)      rd_d[p] = PC_IN;
        end
    end

    assign wconflict_d = wr1_ok && WE2 && (WA1 == WA2);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the storage array is cleared on reset because software relies on zeroed registers;
            // this forces the array into flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            for (int p = 0; p < NPORTS; p++) rd_q[p] <= '0;
            wconflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            if (RE) begin
                for (int p = 0; p < NPORTS; p++) rd_q[p] <= rd_d[p];
            end
            wconflict_q <= wconflict_d;
        end
    end

    assign RD1       = rd_q[0];
    assign RD2       = rd_q[1];
    assign RD3       = rd_q[2];
    assign WCONFLICT = wconflict_q;

endmodule
